// File: rtl/femto_clk_pkg.sv
// Shared definitions for the board clocking slice: sequencer state encoding,
// width helpers and the PLL multiplier settings used by the PLL wrapper.
package femto_clk_pkg;

   // Sequencer states; the numeric values are visible on state_dbg.
   typedef enum logic [2:0] {
      ST_PLLRST    = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_STABLE    = 3'd2,
      ST_RELEASE   = 3'd3,
      ST_RUN       = 3'd4,
      ST_FAULT     = 3'd5
   } seq_state_e;

   // PLL configuration shared with the PLLE2_ADV wrapper (100 MHz in, 1 GHz VCO).
   localparam int PLL_CLKIN_PERIOD_NS = 10;
   localparam int PLL_DIVCLK_DIVIDE   = 1;
   localparam int PLL_CLKFBOUT_MULT   = 10;
   localparam int PLL_CLKOUT0_DIVIDE  = 20;
   localparam int PLL_CLKOUT1_DIVIDE  = 10;

   // Larger of two integers, for sizing counters from several limits.
   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Bits needed to hold every value 0..v, never less than one.
   function automatic int width_for(input int v);
      int w;
      w = 1;
      while ((w < 31) && ((1 << w) <= v)) begin
         w = w + 1;
      end
      return w;
   endfunction

   // Width of the shared sequencer timer, sized for the longest interval it measures.
   function automatic int timer_width(input int timeout, input int stable,
                                      input int rst_cycles, input int release_span);
      return width_for(max_int(max_int(timeout, stable), max_int(rst_cycles, release_span)));
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single level signal arriving from another clock domain.
module sync_2ff
   import femto_clk_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic meta_d;
   logic sync_q;
   logic sync_d;

   // Each stage simply takes the value of the stage before it.
   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   // The first flop may go metastable; the second gives it a full cycle to settle.
   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL supervisor: pulses the PLL reset, waits for a qualified lock (with timeout
// and bounded retries), then releases the downstream resets one channel at a time.
// Any lock loss after release pulls every reset back and restarts the sequence.
module pll_reset_sequencer
   import femto_clk_pkg::*;
#(
   parameter int NCHAN          = 3,
   parameter int PLL_RST_CYCLES = 16,
   parameter int LOCK_TIMEOUT   = 100000,
   parameter int LOCK_STABLE    = 256,
   parameter int STAGGER        = 16,
   parameter int MAX_RETRIES    = 0,
   parameter int CNT_W          = 8
)(
   input  logic             pclk,
   input  logic             reset,
   input  logic             pll_locked,
   output logic             pll_rst,
   output logic [NCHAN-1:0] rst_out,
   output logic             ready,
   output logic             fault,
   output logic [CNT_W-1:0] lock_lost_count,
   output logic [2:0]       state_dbg
);

   localparam int TMR_W = timer_width(LOCK_TIMEOUT, LOCK_STABLE, PLL_RST_CYCLES, NCHAN * STAGGER);
   localparam int RTY_W = width_for(MAX_RETRIES);

   localparam logic [TMR_W-1:0] RST_LAST = TMR_W'(PLL_RST_CYCLES - 1);
   localparam logic [TMR_W-1:0] TO_LAST  = TMR_W'(LOCK_TIMEOUT - 1);
   localparam logic [TMR_W-1:0] STB_LAST = TMR_W'(LOCK_STABLE - 1);
   localparam logic [TMR_W-1:0] STG_LAST = TMR_W'(STAGGER - 1);
   localparam logic [RTY_W-1:0] RTY_LAST = RTY_W'(MAX_RETRIES - 1);

   logic             locked_s;

   seq_state_e       state_q;
   seq_state_e       state_d;
   logic [TMR_W-1:0] timer_q;
   logic [TMR_W-1:0] timer_d;
   logic [RTY_W-1:0] retries_q;
   logic [RTY_W-1:0] retries_d;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic [NCHAN-1:0] rst_out_q;
   logic [NCHAN-1:0] rst_out_d;
   logic             pll_rst_q;
   logic             pll_rst_d;
   logic             ready_q;
   logic             ready_d;
   logic             fault_q;
   logic             fault_d;

   sync_2ff u_lock_sync (
      .clk   (pclk),
      .reset (reset),
      .d     (pll_locked),
      .q     (locked_s)
   );

   // Next-state logic; outputs are derived from the state being entered so they are registered.
   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q + TMR_W'(1);
      retries_d = retries_q;
      count_d   = count_q;
      rst_out_d = rst_out_q;

      case (state_q)
         ST_PLLRST: begin
            if (timer_q == RST_LAST) begin
               state_d = ST_WAIT_LOCK;
               timer_d = '0;
            end
         end

         ST_WAIT_LOCK: begin
            if (locked_s) begin
               state_d = ST_STABLE;
               timer_d = '0;
            end else if (timer_q == TO_LAST) begin
               timer_d = '0;
               if ((MAX_RETRIES != 0) && (retries_q == RTY_LAST)) begin
                  state_d = ST_FAULT;
               end else begin
                  state_d = ST_PLLRST;
               end
               if (MAX_RETRIES != 0) begin
                  retries_d = retries_q + RTY_W'(1);
               end
            end
         end

         ST_STABLE: begin
            if (!locked_s) begin
               state_d = ST_WAIT_LOCK;
               timer_d = '0;
            end else if (timer_q == STB_LAST) begin
               state_d = ST_RELEASE;
               timer_d = '0;
            end
         end

         ST_RELEASE: begin
            if (!locked_s) begin
               state_d   = ST_PLLRST;
               timer_d   = '0;
               retries_d = '0;
               if (count_q != '1) begin
                  count_d = count_q + CNT_W'(1);
               end
            end else begin
               if (timer_q == STG_LAST) begin
                  timer_d = '0;
               end
               if (timer_q == '0) begin
                  rst_out_d = rst_out_q << 1;
                  if (rst_out_d == '0) begin
                     state_d = ST_RUN;
                     timer_d = '0;
                  end
               end
            end
         end

         ST_RUN: begin
            timer_d = timer_q;
            if (!locked_s) begin
               state_d   = ST_PLLRST;
               timer_d   = '0;
               retries_d = '0;
               if (count_q != '1) begin
                  count_d = count_q + CNT_W'(1);
               end
            end
         end

         ST_FAULT: begin
            timer_d = timer_q;
         end

         default: begin
            state_d = ST_PLLRST;
            timer_d = '0;
         end
      endcase

      if (state_d inside {ST_PLLRST, ST_WAIT_LOCK, ST_STABLE, ST_FAULT}) begin
         rst_out_d = '1;
      end
      pll_rst_d = (state_d == ST_PLLRST) || (state_d == ST_FAULT);
      ready_d   = (state_d == ST_RUN);
      fault_d   = (state_d == ST_FAULT);
   end

   // State, timer and output registers; reset puts the PLL back into reset with everything held.
   always_ff @(posedge pclk) begin
      if (reset) begin
         state_q   <= ST_PLLRST;
         timer_q   <= '0;
         retries_q <= '0;
         count_q   <= '0;
         rst_out_q <= '1;
         pll_rst_q <= 1'b1;
         ready_q   <= 1'b0;
         fault_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         retries_q <= retries_d;
         count_q   <= count_d;
         rst_out_q <= rst_out_d;
         pll_rst_q <= pll_rst_d;
         ready_q   <= ready_d;
         fault_q   <= fault_d;
      end
   end

   assign pll_rst         = pll_rst_q;
   assign rst_out         = rst_out_q;
   assign ready           = ready_q;
   assign fault           = fault_q;
   assign lock_lost_count = count_q;
   assign state_dbg       = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Testbench for pll_reset_sequencer: directed scenarios plus a randomized lock
// pattern compared cycle by cycle against a phase/elapsed-time reference model.
module tb_pll_reset_sequencer;

   localparam int NCHAN          = 3;
   localparam int PLL_RST_CYCLES = 4;
   localparam int LOCK_TIMEOUT   = 50;
   localparam int LOCK_STABLE    = 8;
   localparam int STAGGER        = 3;
   localparam int MAX_RETRIES    = 2;
   localparam int CNT_W          = 2;
   localparam int CNT_MAX        = (1 << CNT_W) - 1;
   localparam int RELEASE_SPAN   = 1 + (NCHAN - 1) * STAGGER;

   localparam int P_PLLRST  = 0;
   localparam int P_WAIT    = 1;
   localparam int P_STABLE  = 2;
   localparam int P_RELEASE = 3;
   localparam int P_RUN     = 4;
   localparam int P_FAULT   = 5;

   logic             pclk = 1'b0;
   logic             reset = 1'b1;
   logic             pll_locked = 1'b0;
   logic             pll_rst;
   logic [NCHAN-1:0] rst_out;
   logic             ready;
   logic             fault;
   logic [CNT_W-1:0] lock_lost_count;
   logic [2:0]       state_dbg;

   int errors = 0;
   int checks = 0;

   int m_phase = 0;
   int m_age   = 0;
   int m_tries = 0;
   int m_lost  = 0;
   bit m_s1    = 1'b0;
   bit m_s2    = 1'b0;

   always #5 pclk = ~pclk;

   pll_reset_sequencer #(
      .NCHAN          (NCHAN),
      .PLL_RST_CYCLES (PLL_RST_CYCLES),
      .LOCK_TIMEOUT   (LOCK_TIMEOUT),
      .LOCK_STABLE    (LOCK_STABLE),
      .STAGGER        (STAGGER),
      .MAX_RETRIES    (MAX_RETRIES),
      .CNT_W          (CNT_W)
   ) dut (
      .pclk            (pclk),
      .reset           (reset),
      .pll_locked      (pll_locked),
      .pll_rst         (pll_rst),
      .rst_out         (rst_out),
      .ready           (ready),
      .fault           (fault),
      .lock_lost_count (lock_lost_count),
      .state_dbg       (state_dbg)
   );

   // Reference model: tracks the current phase and how long it has lasted.
   always @(posedge pclk) begin : ref_model
      bit ls;
      ls   = m_s2;
      m_s2 = m_s1;
      m_s1 = pll_locked;
      if (reset) begin
         m_phase = P_PLLRST; m_age = 0; m_tries = 0; m_lost = 0; m_s1 = 1'b0; m_s2 = 1'b0;
      end else begin
         case (m_phase)
            P_PLLRST: begin
               if (m_age + 1 == PLL_RST_CYCLES) begin m_phase = P_WAIT; m_age = 0; end
               else m_age++;
            end
            P_WAIT: begin
               if (ls) begin m_phase = P_STABLE; m_age = 0; end
               else if (m_age + 1 == LOCK_TIMEOUT) begin
                  m_tries++;
                  m_phase = (MAX_RETRIES != 0 && m_tries == MAX_RETRIES) ? P_FAULT : P_PLLRST;
                  m_age = 0;
               end else m_age++;
            end
            P_STABLE: begin
               if (!ls) begin m_phase = P_WAIT; m_age = 0; end
               else if (m_age + 1 == LOCK_STABLE) begin m_phase = P_RELEASE; m_age = 0; end
               else m_age++;
            end
            P_RELEASE, P_RUN: begin
               if (!ls) begin
                  m_phase = P_PLLRST; m_age = 0; m_tries = 0;
                  m_lost = (m_lost < CNT_MAX) ? m_lost + 1 : CNT_MAX;
               end else if (m_phase == P_RELEASE && m_age + 1 == RELEASE_SPAN) begin
                  m_phase = P_RUN; m_age = 0;
               end else m_age++;
            end
            default: ;
         endcase
      end
   end

   // Channel k is released once 1 + k*STAGGER cycles of the release phase have elapsed.
   function automatic logic [NCHAN-1:0] model_rst_out();
      logic [NCHAN-1:0] r;
      r = '1;
      if (m_phase == P_RUN) r = '0;
      else if (m_phase == P_RELEASE) begin
         for (int k = 0; k < NCHAN; k++) if (m_age >= 1 + k * STAGGER) r[k] = 1'b0;
      end
      return r;
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge pclk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(2);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      pll_locked = 1'b0;
      do_reset();
      checks++; if (pll_rst !== 1'b1) begin errors++; $display("[TB] FAIL reset_pll_rst got=%b exp=1", pll_rst); end
      checks++; if (rst_out !== 3'b111) begin errors++; $display("[TB] FAIL reset_rst_out got=%b exp=111", rst_out); end
      checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready got=%b exp=0", ready); end
      checks++; if (fault !== 1'b0) begin errors++; $display("[TB] FAIL reset_fault got=%b exp=0", fault); end
      checks++; if (lock_lost_count !== 2'd0) begin errors++; $display("[TB] FAIL reset_count got=%0d exp=0", lock_lost_count); end
      checks++; if (state_dbg !== 3'd0) begin errors++; $display("[TB] FAIL reset_state got=%0d exp=0", state_dbg); end
   endtask

   task automatic test_lock_sequence();
      int hi_cnt, c110, c100, c000, crdy, t_rel;
      logic [NCHAN-1:0] rdy_rst;
      hi_cnt = 0; c110 = -1; c100 = -1; c000 = -1; crdy = -1; rdy_rst = 'x;
      do_reset();
      pll_locked = 1'b1;
      for (int cyc = 0; cyc < 60; cyc++) begin
         if (pll_rst === 1'b1) hi_cnt++;
         if (c110 < 0 && rst_out === 3'b110) c110 = cyc;
         if (c100 < 0 && rst_out === 3'b100) c100 = cyc;
         if (c000 < 0 && rst_out === 3'b000) c000 = cyc;
         if (crdy < 0 && ready === 1'b1) begin crdy = cyc; rdy_rst = rst_out; end
         step(1);
      end
      // Lock is already synchronised when waiting starts, so stable begins one cycle after the pulse.
      t_rel = PLL_RST_CYCLES + 1 + LOCK_STABLE;
      checks++; if (hi_cnt !== PLL_RST_CYCLES) begin errors++; $display("[TB] FAIL seq_pll_rst_len got=%0d exp=%0d", hi_cnt, PLL_RST_CYCLES); end
      checks++; if (c110 !== t_rel + 1) begin errors++; $display("[TB] FAIL seq_110_cycle got=%0d exp=%0d", c110, t_rel + 1); end
      checks++; if (c100 !== t_rel + 1 + STAGGER) begin errors++; $display("[TB] FAIL seq_100_cycle got=%0d exp=%0d", c100, t_rel + 1 + STAGGER); end
      checks++; if (c000 !== t_rel + 1 + 2 * STAGGER) begin errors++; $display("[TB] FAIL seq_000_cycle got=%0d exp=%0d", c000, t_rel + 1 + 2 * STAGGER); end
      checks++; if (crdy !== t_rel + 1 + 2 * STAGGER) begin errors++; $display("[TB] FAIL seq_ready_cycle got=%0d exp=%0d", crdy, t_rel + 1 + 2 * STAGGER); end
      checks++; if (rdy_rst !== 3'b000) begin errors++; $display("[TB] FAIL seq_ready_rst got=%b exp=000", rdy_rst); end
      checks++; if (lock_lost_count !== 2'd0) begin errors++; $display("[TB] FAIL seq_count got=%0d exp=0", lock_lost_count); end
   endtask

   task automatic test_timeout_fault();
      int chg[$];
      int exp_chg[4];
      int fault_cyc, got_chg;
      logic prev;
      do_reset();
      pll_locked = 1'b0;
      prev = pll_rst; fault_cyc = -1;
      for (int cyc = 0; cyc < 140; cyc++) begin
         if (cyc > 0 && pll_rst !== prev) chg.push_back(cyc);
         prev = pll_rst;
         if (fault_cyc < 0 && fault === 1'b1) fault_cyc = cyc;
         step(1);
      end
      exp_chg[0] = PLL_RST_CYCLES;
      exp_chg[1] = PLL_RST_CYCLES + LOCK_TIMEOUT;
      exp_chg[2] = 2 * PLL_RST_CYCLES + LOCK_TIMEOUT;
      exp_chg[3] = 2 * (PLL_RST_CYCLES + LOCK_TIMEOUT);
      checks++; if (chg.size() !== 4) begin errors++; $display("[TB] FAIL timeout_edge_count got=%0d exp=4", chg.size()); end
      for (int i = 0; i < 4; i++) begin
         got_chg = (chg.size() > i) ? chg[i] : -1;
         checks++; if (got_chg !== exp_chg[i]) begin errors++; $display("[TB] FAIL timeout_edge%0d got=%0d exp=%0d", i, got_chg, exp_chg[i]); end
      end
      checks++; if (fault_cyc !== exp_chg[3]) begin errors++; $display("[TB] FAIL fault_cycle got=%0d exp=%0d", fault_cyc, exp_chg[3]); end
      checks++; if (pll_rst !== 1'b1 || rst_out !== 3'b111 || ready !== 1'b0) begin
         errors++; $display("[TB] FAIL fault_outputs got=%b/%b/%b exp=1/111/0", pll_rst, rst_out, ready); end
      checks++; if (state_dbg !== 3'd5) begin errors++; $display("[TB] FAIL fault_state got=%0d exp=5", state_dbg); end
      do_reset();
      checks++; if (fault !== 1'b0) begin errors++; $display("[TB] FAIL fault_clear got=%b exp=0", fault); end
      checks++; if (state_dbg !== 3'd0 || pll_rst !== 1'b1) begin
         errors++; $display("[TB] FAIL fault_restart got=%0d/%b exp=0/1", state_dbg, pll_rst); end
   endtask

   task automatic test_lock_loss();
      bit got;
      do_reset();
      pll_locked = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin if (ready === 1'b1) got = 1'b1; else step(1); end
      checks++; if (!got) begin errors++; $display("[TB] FAIL loss_reach_ready got=0 exp=1"); end
      step(4);
      pll_locked = 1'b0;
      step(2);
      checks++; if (rst_out !== 3'b000 || ready !== 1'b1) begin
         errors++; $display("[TB] FAIL loss_too_early got=%b/%b exp=000/1", rst_out, ready); end
      step(1);
      checks++; if (rst_out !== 3'b111 || ready !== 1'b0 || pll_rst !== 1'b1) begin
         errors++; $display("[TB] FAIL loss_e3_outputs got=%b/%b/%b exp=111/0/1", rst_out, ready, pll_rst); end
      checks++; if (lock_lost_count !== 2'd1) begin errors++; $display("[TB] FAIL loss_count got=%0d exp=1", lock_lost_count); end
      checks++; if (state_dbg !== 3'd0) begin errors++; $display("[TB] FAIL loss_state got=%0d exp=0", state_dbg); end
      pll_locked = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin if (ready === 1'b1) got = 1'b1; else step(1); end
      checks++; if (!got || rst_out !== 3'b000) begin
         errors++; $display("[TB] FAIL loss_resequence got=%b/%b exp=1/000", got, rst_out); end
   endtask

   task automatic test_glitch();
      int early, c110, st12, st14;
      early = 0; c110 = -1; st12 = -1; st14 = -1;
      do_reset();
      for (int cyc = 0; cyc < 40; cyc++) begin
         if (cyc < 24 && rst_out !== 3'b111) early++;
         if (c110 < 0 && rst_out === 3'b110) c110 = cyc;
         if (cyc == 12) st12 = int'(state_dbg);
         if (cyc == 14) st14 = int'(state_dbg);
         pll_locked = ((cyc >= 6 && cyc <= 10) || cyc >= 12);
         step(1);
      end
      // Synchronised lock is high 8..12, low 13: stable from 9, back to waiting at 14,
      // fresh stable from 15, release at 15+LOCK_STABLE, first channel one cycle later.
      checks++; if (st12 !== P_STABLE) begin errors++; $display("[TB] FAIL glitch_in_stable got=%0d exp=%0d", st12, P_STABLE); end
      checks++; if (st14 !== P_WAIT) begin errors++; $display("[TB] FAIL glitch_back_wait got=%0d exp=%0d", st14, P_WAIT); end
      checks++; if (c110 !== 15 + LOCK_STABLE + 1) begin errors++; $display("[TB] FAIL glitch_110_cycle got=%0d exp=%0d", c110, 15 + LOCK_STABLE + 1); end
      checks++; if (early !== 0) begin errors++; $display("[TB] FAIL glitch_early_release got=%0d exp=0", early); end
      checks++; if (lock_lost_count !== 2'd0) begin errors++; $display("[TB] FAIL glitch_count got=%0d exp=0", lock_lost_count); end
   endtask

   task automatic test_saturate();
      bit got;
      int exp_cnt;
      do_reset();
      for (int i = 1; i <= 4; i++) begin
         pll_locked = 1'b1;
         got = 1'b0;
         for (int j = 0; j < 100 && !got; j++) begin if (ready === 1'b1) got = 1'b1; else step(1); end
         checks++; if (!got) begin errors++; $display("[TB] FAIL sat_ready%0d got=0 exp=1", i); end
         pll_locked = 1'b0;
         step(3);
         exp_cnt = (i > CNT_MAX) ? CNT_MAX : i;
         checks++; if (lock_lost_count !== CNT_W'(exp_cnt)) begin
            errors++; $display("[TB] FAIL sat_count%0d got=%0d exp=%0d", i, lock_lost_count, exp_cnt); end
      end
   endtask

   task automatic test_reset_mid_release();
      bit got;
      pll_locked = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin if (rst_out === 3'b110) got = 1'b1; else step(1); end
      checks++; if (!got) begin errors++; $display("[TB] FAIL midrel_reach_110 got=0 exp=1"); end
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      checks++; if (rst_out !== 3'b111 || pll_rst !== 1'b1) begin
         errors++; $display("[TB] FAIL midrel_outputs got=%b/%b exp=111/1", rst_out, pll_rst); end
      checks++; if (state_dbg !== 3'd0) begin errors++; $display("[TB] FAIL midrel_state got=%0d exp=0", state_dbg); end
      checks++; if (lock_lost_count !== 2'd0) begin errors++; $display("[TB] FAIL midrel_count got=%0d exp=0", lock_lost_count); end
   endtask

   task automatic test_random();
      int run_left;
      bit lvl;
      logic [10:0] got_v, exp_v;
      run_left = 0; lvl = 1'b0;
      do_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         got_v = {pll_rst, rst_out, ready, fault, lock_lost_count, state_dbg};
         exp_v = {(m_phase == P_PLLRST || m_phase == P_FAULT), model_rst_out(),
                  (m_phase == P_RUN), (m_phase == P_FAULT), CNT_W'(m_lost), 3'(m_phase)};
         checks++; if (got_v !== exp_v) begin
            errors++; $display("[TB] FAIL random_cycle%0d got=%b exp=%b", cyc, got_v, exp_v); end
         if (run_left == 0) begin
            lvl = !lvl;
            run_left = lvl ? int'($urandom_range(80, 1)) : int'($urandom_range(70, 1));
         end
         pll_locked = lvl;
         run_left--;
         reset = ($urandom_range(150, 0) == 0);
         step(1);
      end
      reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_lock_sequence();
      test_timeout_fault();
      test_lock_loss();
      test_glitch();
      test_saturate();
      test_reset_mid_release();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
